// File: rtl/mcc_pkg.sv
// rtl/mcc_pkg.sv - shared states, opcodes, ALUop codes and mux selects for multicycle_ctrl
package mcc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_RTYPE = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  function automatic logic [3:0] alu_op_for_imm(input logic [5:0] op);
    return (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
  endfunction

endpackage

// File: rtl/mcc_next_state.sv
// rtl/mcc_next_state.sv - opcode/funct decode to the state that follows DECODE
module mcc_next_state
  import mcc_pkg::*;
(
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  output state_t     decode_next_o
);

  // Unknown opcodes fall back to FETCH so they retire as a NOP.
  always_comb begin
    decode_next_o = S_FETCH;
    case (instr_op_i)
      OP_RTYPE:       decode_next_o = (funct_i == FUNCT_JR) ? S_JR : S_EXEC_R;
      OP_ADDI, OP_SLTI: decode_next_o = S_EXEC_I;
      OP_LW, OP_SW:   decode_next_o = S_MEM_ADDR;
      OP_BEQ, OP_BNE: decode_next_o = S_BRANCH;
      OP_J, OP_JAL:   decode_next_o = S_JUMP;
      default:        decode_next_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FSM sequencer; MULTICYCLE_PERF_EN adds cycle/instr counters
module multicycle_ctrl
  import mcc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic [5:0]       funct_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             iord_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [3:0]       alu_op_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
`endif
);

  if (ADDR_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_ctrl: ADDR_W and CNT_W must be positive");
  end

  state_t state_q, state_d, decode_next;
  logic   rtype_q, lw_q;

  mcc_next_state u_next_state (
    .instr_op_i    (instr_op_i),
    .funct_i       (funct_i),
    .decode_next_o (decode_next)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      rtype_q <= 1'b0;
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        rtype_q <= (instr_op_i == OP_RTYPE);
        lw_q    <= (instr_op_i == OP_LW);
      end
    end
  end

  // Everything stays zero while rst_i is low so no write can leak out mid-reset.
  always_comb begin
    state_d      = state_q;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRC_B_RT;
    alu_op_o     = ALU_ADD;
    reg_dst_o    = REG_DST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    pc_source_o  = PC_SRC_ALU;
    state_o      = S_FETCH;
    if (rst_i) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRC_B_FOUR;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
          state_d     = mem_ready_i ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b_o = SRC_B_IMM_SH;
          state_d     = decode_next;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_RTYPE;
          reg_dst_o   = REG_DST_RD;
          state_d     = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRC_B_IMM;
          alu_op_o    = alu_op_for_imm(instr_op_i);
          state_d     = S_WB_ALU;
        end
        S_WB_ALU: begin
          reg_write_o = 1'b1;
          reg_dst_o   = rtype_q ? REG_DST_RD : REG_DST_RT;
          state_d     = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRC_B_IMM;
          state_d     = lw_q ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
          state_d    = mem_ready_i ? S_WB_MEM : S_MEM_RD;
        end
        S_WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_MDR;
          state_d      = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
          state_d     = mem_ready_i ? S_FETCH : S_MEM_WR;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          pc_source_o = PC_SRC_ALUOUT;
          pc_write_o  = branch_taken_i;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          pc_source_o = PC_SRC_JUMP;
          pc_write_o  = 1'b1;
          if (instr_op_i == OP_JAL) begin
            reg_write_o  = 1'b1;
            reg_dst_o    = REG_DST_RA;
            mem_to_reg_o = M2R_PC;
          end
          state_d = S_FETCH;
        end
        S_JR: begin
          pc_source_o = PC_SRC_RS;
          pc_write_o  = 1'b1;
          state_d     = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_o <= '0;
      instr_cnt_o <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
      if (state_q != S_FETCH && state_d == S_FETCH)
        instr_cnt_o <= instr_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - per-cycle vector table plus reset/perf sequences; honours MULTICYCLE_PERF_EN
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic [5:0] funct_i;
  logic       branch_taken_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, iord_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, reg_dst_o, mem_to_reg_o, pc_source_o;
  logic [3:0] alu_op_o, state_o;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

  int tests  = 0;
  int failed = 0;

  multicycle_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .instr_op_i     (instr_op_i),
    .funct_i        (funct_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .ir_write_o     (ir_write_o),
    .reg_write_o    (reg_write_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .iord_o         (iord_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .reg_dst_o      (reg_dst_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .pc_source_o    (pc_source_o),
    .state_o        (state_o)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_cnt_o    (cycle_cnt_o),
    .instr_cnt_o    (instr_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp layout: {state, pcw, irw, rw, mrd, mwr, iord, src_a, src_b, alu_op, reg_dst, m2r, pc_src}
  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        bt;
    logic        mr;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(int op, int fn, int bt, int mr, int st, int pcw, int irw, int rw,
                               int mrd, int mwr, int iord, int sa, int sb, int aop, int rd,
                               int m2r, int ps);
    vec_t r;
    r.op  = op[5:0];
    r.fn  = fn[5:0];
    r.bt  = bt[0];
    r.mr  = mr[0];
    r.exp = {st[3:0], pcw[0], irw[0], rw[0], mrd[0], mwr[0], iord[0], sa[0], sb[1:0],
             aop[3:0], rd[1:0], m2r[1:0], ps[1:0]};
    return r;
  endfunction

  function automatic logic [22:0] got();
    return {state_o, pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, iord_o,
            alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o, pc_source_o};
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Fetch (ready) and decode rows are identical for every instruction.
  task automatic push_fd(int op, int fn);
    vecs.push_back(row(op, fn, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(row(op, fn, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
  endtask

  initial begin
    rst_i = 1'b0; instr_op_i = '0; funct_i = '0; branch_taken_i = 1'b0; mem_ready_i = 1'b1;

    // add
    push_fd('h00, 'h20);
    vecs.push_back(row('h00, 'h20, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(row('h00, 'h20, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // lw with a 3-cycle memory stall
    push_fd('h23, 0);
    vecs.push_back(row('h23, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(row('h23, 0, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row('h23, 0, 0, 1, 5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row('h23, 0, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // sw with one stall cycle
    push_fd('h2B, 0);
    vecs.push_back(row('h2B, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(row('h2B, 0, 0, 0, 6, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row('h2B, 0, 0, 1, 6, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // beq not taken, then taken
    push_fd('h04, 0);
    vecs.push_back(row('h04, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    push_fd('h04, 0);
    vecs.push_back(row('h04, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    // jal, jr
    push_fd('h03, 0);
    vecs.push_back(row('h03, 0, 0, 1, 10, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 2, 2));
    push_fd('h00, 'h08);
    vecs.push_back(row('h00, 'h08, 0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // illegal opcode retires straight from DECODE
    push_fd('h3F, 0);
    // slti
    push_fd('h0A, 0);
    vecs.push_back(row('h0A, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0));
    vecs.push_back(row('h0A, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // j after a stalled fetch
    vecs.push_back(row('h02, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    push_fd('h02, 0);
    vecs.push_back(row('h02, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    // sll $0 (op 0, funct 0)
    push_fd('h00, 'h00);
    vecs.push_back(row('h00, 'h00, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(row('h00, 'h00, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // bne taken, then addi
    push_fd('h05, 0);
    vecs.push_back(row('h05, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    push_fd('h08, 0);
    vecs.push_back(row('h08, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(row('h08, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state: outputs all zero while rst_i is low, even with mem_ready_i high.
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {9'd0, got()}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      instr_op_i     = vecs[i].op;
      funct_i        = vecs[i].fn;
      branch_taken_i = vecs[i].bt;
      mem_ready_i    = vecs[i].mr;
      #1;
      tests++;
      if (got() !== vecs[i].exp) begin
        failed++;
        $display("FAIL vec%0d op=%h: got %h expected %h", i, vecs[i].op, got(), vecs[i].exp);
      end
      @(negedge clk);
    end

    // Reset asserted while a store is stalled in MEM_WR.
    instr_op_i = 6'h2B; funct_i = '0; branch_taken_i = 1'b0; mem_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready_i = 1'b0;
    #1 check("memwr_before_reset", {28'd0, state_o}, 32'd6);
    check("memwr_asserted", {31'd0, mem_write_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1 check("memwr_abort", {31'd0, mem_write_o}, 32'd0);
    check("reset_mid_outputs", {9'd0, got()}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    mem_ready_i = 1'b1;
    instr_op_i = 6'h3F;
    #1 check("after_release_state", {28'd0, state_o}, 32'd0);
    check("after_release_memread", {31'd0, mem_read_o}, 32'd1);
`ifdef MULTICYCLE_PERF_EN
    check("perf_reset_cycle", cycle_cnt_o, 32'd0);
    check("perf_reset_instr", instr_cnt_o, 32'd0);
`endif

    // Illegal op: FETCH -> DECODE -> FETCH with no write enables.
    @(negedge clk);
    #1 check("illegal_decode", {28'd0, state_o}, 32'd1);
    check("illegal_no_writes", {29'd0, reg_write_o, mem_write_o, pc_write_o}, 32'd0);
    @(negedge clk);
    #1 check("illegal_back_fetch", {28'd0, state_o}, 32'd0);
`ifdef MULTICYCLE_PERF_EN
    check("perf_instr_illegal", instr_cnt_o, 32'd1);
    check("perf_cycle", cycle_cnt_o, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
